// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG marker parser: FSM state encoding,
// marker byte values, error cause codes and the segment classifier.
package aq_djpeg_pkg;

   // FSM state encoding
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_MRK_FF   = 4'd1;
   localparam logic [3:0] ST_MRK_ID   = 4'd2;
   localparam logic [3:0] ST_LEN_HI   = 4'd3;
   localparam logic [3:0] ST_LEN_LO   = 4'd4;
   localparam logic [3:0] ST_SKIP     = 4'd5;
   localparam logic [3:0] ST_DQT_PQ   = 4'd6;
   localparam logic [3:0] ST_DQT_DATA = 4'd7;
   localparam logic [3:0] ST_DHT_TC   = 4'd8;
   localparam logic [3:0] ST_DHT_BITS = 4'd9;
   localparam logic [3:0] ST_DHT_VALS = 4'd10;
   localparam logic [3:0] ST_SOF_BODY = 4'd11;
   localparam logic [3:0] ST_SOS_BODY = 4'd12;
   localparam logic [3:0] ST_DRI_BODY = 4'd13;
   localparam logic [3:0] ST_SCAN     = 4'd14;
   localparam logic [3:0] ST_ERROR    = 4'd15;

   // Marker identifiers (the byte that follows 0xFF)
   localparam logic [7:0] MRK_FILL = 8'hFF;
   localparam logic [7:0] MRK_SOI  = 8'hD8;
   localparam logic [7:0] MRK_EOI  = 8'hD9;
   localparam logic [7:0] MRK_DQT  = 8'hDB;
   localparam logic [7:0] MRK_DHT  = 8'hC4;
   localparam logic [7:0] MRK_SOF0 = 8'hC0;
   localparam logic [7:0] MRK_SOF1 = 8'hC1;
   localparam logic [7:0] MRK_SOF2 = 8'hC2;
   localparam logic [7:0] MRK_SOS  = 8'hDA;
   localparam logic [7:0] MRK_DRI  = 8'hDD;
   localparam logic [7:0] MRK_JPG  = 8'hC8;
   localparam logic [7:0] MRK_DAC  = 8'hCC;

   // First-error cause codes reported on err_code
   localparam logic [2:0] ERR_NONE            = 3'd0;
   localparam logic [2:0] ERR_BAD_MARKER      = 3'd1;
   localparam logic [2:0] ERR_UNSUPPORTED_SOF = 3'd2;
   localparam logic [2:0] ERR_BAD_LENGTH      = 3'd3;
   localparam logic [2:0] ERR_BAD_TABLE       = 3'd4;
   localparam logic [2:0] ERR_DHT_COUNT       = 3'd5;
   localparam logic [2:0] ERR_BAD_NCOMP       = 3'd6;
   localparam logic [2:0] ERR_OVERRUN         = 3'd7;

   // Which body parser a length-prefixed segment is routed to
   typedef enum logic [2:0] {
      SEG_SKIP = 3'd0,
      SEG_DQT  = 3'd1,
      SEG_DHT  = 3'd2,
      SEG_SOF  = 3'd3,
      SEG_SOS  = 3'd4,
      SEG_DRI  = 3'd5
   } seg_e;

   // SOFn variants this parser cannot decode (C4/C8/CC share the range
   // but are DHT, JPG and DAC, not frame headers)
   function automatic logic is_unsupported_sof(input logic [7:0] m);
      return (m >= 8'hC3) && (m <= 8'hCF) &&
             (m != MRK_DHT) && (m != MRK_JPG) && (m != MRK_DAC);
   endfunction

endpackage

// File: rtl/aq_djpeg_seg_counter.sv
// Remaining-length counter for the segment body: loaded with L-2 after
// the length field, decremented once per consumed body byte.
module aq_djpeg_seg_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        dec,
   output logic [15:0] count,
   output logic        zero
);

   logic [15:0] count_q, count_d;

   // Next count: load wins over decrement; never wraps below zero
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != 16'd0)) begin
         count_d = count_q - 16'd1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == 16'd0);

endmodule

// File: rtl/aq_djpeg_marker_parser.sv
// JPEG header marker parser. Byte stream handshake: a byte moves when
// s_valid and s_ready are both high on a rising clk edge; s_valid may be
// held or dropped freely, s_data must be stable while s_valid is high.
// Table writes, scan_start and eoi are registered one-cycle pulses.
module aq_djpeg_marker_parser
   import aq_djpeg_pkg::*;
#(
   parameter int unsigned MAX_COMP = 4,
   parameter int unsigned NUM_DQT  = 4,
   parameter int unsigned DQT16_EN = 1,
   parameter int unsigned DRI_EN   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   input  logic        scan_done,
   output logic        idle,
   output logic        dqt_we,
   output logic [1:0]  dqt_id,
   output logic [5:0]  dqt_addr,
   output logic [15:0] dqt_data,
   output logic        dht_bits_we,
   output logic [1:0]  dht_sel,
   output logic [3:0]  dht_bits_idx,
   output logic        dht_vals_we,
   output logic [7:0]  dht_vals_idx,
   output logic [7:0]  dht_data,
   output logic [15:0] width,
   output logic [15:0] height,
   output logic [2:0]  num_comp,
   output logic        progressive,
   output logic [1:0]  samp_h,
   output logic [1:0]  samp_v,
   output logic [15:0] restart_interval,
   output logic [2:0]  scan_ncomp,
   output logic        scan_start,
   output logic        eoi,
   output logic        err,
   output logic [2:0]  err_code,
   output logic [3:0]  state_dbg
);

   localparam logic [7:0] MAX_COMP_B = 8'(MAX_COMP);
   localparam logic [3:0] NUM_DQT_B  = 4'(NUM_DQT);

   // Parser context
   logic [3:0]  state_q, state_d;
   seg_e        seg_q, seg_d;
   logic [7:0]  len_hi_q, len_hi_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  tq_q, tq_d;
   logic        pq_q, pq_d;
   logic        phase_q, phase_d;
   logic [7:0]  dqt_hi_q, dqt_hi_d;
   logic [11:0] sum_q, sum_d;

   // Registered outputs
   logic        dqt_we_q, dqt_we_d;
   logic [1:0]  dqt_id_q, dqt_id_d;
   logic [5:0]  dqt_addr_q, dqt_addr_d;
   logic [15:0] dqt_data_q, dqt_data_d;
   logic        dht_bits_we_q, dht_bits_we_d;
   logic        dht_vals_we_q, dht_vals_we_d;
   logic [1:0]  dht_sel_q, dht_sel_d;
   logic [3:0]  dht_bits_idx_q, dht_bits_idx_d;
   logic [7:0]  dht_vals_idx_q, dht_vals_idx_d;
   logic [7:0]  dht_data_q, dht_data_d;
   logic [15:0] width_q, width_d, height_q, height_d;
   logic [2:0]  num_comp_q, num_comp_d;
   logic        progressive_q, progressive_d;
   logic [1:0]  samp_h_q, samp_h_d, samp_v_q, samp_v_d;
   logic [15:0] restart_q, restart_d;
   logic [2:0]  scan_ncomp_q, scan_ncomp_d;
   logic        scan_start_q, scan_start_d;
   logic        eoi_q, eoi_d;
   logic        err_q, err_d;
   logic [2:0]  err_code_q, err_code_d;

   // Remaining-length counter interface
   logic        cnt_load, cnt_dec, rem_zero;
   logic [15:0] cnt_load_val, rem;

   // Combinational helpers
   logic        accept, in_body, body_byte, rem_last, err_set;
   logic [2:0]  err_cause;
   logic [15:0] seg_len;
   logic [11:0] sum_next;
   logic [7:0]  sof_last, sos_last;

   aq_djpeg_seg_counter u_seg_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (rem),
      .zero     (rem_zero)
   );

   assign s_ready = !((state_q == ST_IDLE) || (state_q == ST_SCAN) ||
                      (state_q == ST_ERROR));
   assign accept  = s_valid && s_ready;
   assign in_body = (state_q >= ST_SKIP) && (state_q <= ST_DRI_BODY);

   // Next-state, segment body decoding and output strobe generation
   always_comb begin
      state_d        = state_q;
      seg_d          = seg_q;
      len_hi_d       = len_hi_q;
      cnt_d          = cnt_q;
      tq_d           = tq_q;
      pq_d           = pq_q;
      phase_d        = phase_q;
      dqt_hi_d       = dqt_hi_q;
      sum_d          = sum_q;
      dqt_we_d       = 1'b0;
      dqt_id_d       = dqt_id_q;
      dqt_addr_d     = dqt_addr_q;
      dqt_data_d     = dqt_data_q;
      dht_bits_we_d  = 1'b0;
      dht_vals_we_d  = 1'b0;
      dht_sel_d      = dht_sel_q;
      dht_bits_idx_d = dht_bits_idx_q;
      dht_vals_idx_d = dht_vals_idx_q;
      dht_data_d     = dht_data_q;
      width_d        = width_q;
      height_d       = height_q;
      num_comp_d     = num_comp_q;
      progressive_d  = progressive_q;
      samp_h_d       = samp_h_q;
      samp_v_d       = samp_v_q;
      restart_d      = restart_q;
      scan_ncomp_d   = scan_ncomp_q;
      scan_start_d   = 1'b0;
      eoi_d          = 1'b0;
      err_d          = err_q;
      err_code_d     = err_code_q;
      cnt_load       = 1'b0;
      cnt_load_val   = 16'd0;
      err_set        = 1'b0;
      err_cause      = ERR_NONE;
      seg_len        = {len_hi_q, s_data};
      rem_last       = (rem == 16'd1);
      sum_next       = sum_q + {4'd0, s_data};
      sof_last       = 8'd5 + ({5'd0, num_comp_q} * 8'd3);
      sos_last       = {4'd0, scan_ncomp_q, 1'b0} + 8'd3;
      // A body byte with nothing left in the segment is an overrun
      body_byte      = in_body && accept && !rem_zero;
      cnt_dec        = body_byte;
      if (in_body && accept && rem_zero) begin
         err_set   = 1'b1;
         err_cause = ERR_OVERRUN;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_MRK_FF;
         end
         ST_MRK_FF: begin
            if (accept) begin
               if (s_data == MRK_FILL) begin
                  state_d = ST_MRK_ID;
               end else begin
                  err_set   = 1'b1;
                  err_cause = ERR_BAD_MARKER;
               end
            end
         end
         ST_MRK_ID: begin
            if (accept) begin
               state_d = ST_LEN_HI;
               if (s_data == MRK_FILL) begin
                  state_d = ST_MRK_ID;
               end else if (s_data == MRK_SOI) begin
                  state_d = ST_MRK_FF;
               end else if (s_data == MRK_EOI) begin
                  state_d = ST_IDLE;
                  eoi_d   = 1'b1;
               end else if (s_data == MRK_DQT) begin
                  seg_d = SEG_DQT;
               end else if (s_data == MRK_DHT) begin
                  seg_d = SEG_DHT;
               end else if ((s_data == MRK_SOF0) || (s_data == MRK_SOF1) ||
                            (s_data == MRK_SOF2)) begin
                  seg_d         = SEG_SOF;
                  progressive_d = (s_data == MRK_SOF2);
               end else if (s_data == MRK_SOS) begin
                  seg_d = SEG_SOS;
               end else if ((s_data == MRK_DRI) && (DRI_EN != 0)) begin
                  seg_d = SEG_DRI;
               end else if (is_unsupported_sof(s_data)) begin
                  err_set   = 1'b1;
                  err_cause = ERR_UNSUPPORTED_SOF;
               end else begin
                  seg_d = SEG_SKIP;
               end
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               len_hi_d = s_data;
               state_d  = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               if ((seg_len < 16'd2) || ((seg_q == SEG_DRI) && (seg_len != 16'd4))) begin
                  err_set   = 1'b1;
                  err_cause = ERR_BAD_LENGTH;
               end else begin
                  cnt_load     = 1'b1;
                  cnt_load_val = seg_len - 16'd2;
                  cnt_d        = 8'd0;
                  case (seg_q)
                     SEG_DQT: state_d = (seg_len == 16'd2) ? ST_MRK_FF : ST_DQT_PQ;
                     SEG_DHT: state_d = (seg_len == 16'd2) ? ST_MRK_FF : ST_DHT_TC;
                     SEG_SOF: state_d = ST_SOF_BODY;
                     SEG_SOS: state_d = ST_SOS_BODY;
                     SEG_DRI: state_d = ST_DRI_BODY;
                     default: state_d = (seg_len == 16'd2) ? ST_MRK_FF : ST_SKIP;
                  endcase
               end
            end
         end
         ST_SKIP: begin
            if (body_byte && rem_last) state_d = ST_MRK_FF;
         end
         ST_DQT_PQ: begin
            if (body_byte) begin
               if ((s_data[3:0] >= NUM_DQT_B) || (s_data[7:4] > 4'd1) ||
                   ((s_data[7:4] == 4'd1) && (DQT16_EN == 0))) begin
                  err_set   = 1'b1;
                  err_cause = ERR_BAD_TABLE;
               end else begin
                  pq_d    = s_data[4];
                  tq_d    = s_data[1:0];
                  cnt_d   = 8'd0;
                  phase_d = 1'b0;
                  state_d = ST_DQT_DATA;
               end
            end
         end
         ST_DQT_DATA: begin
            if (body_byte) begin
               if (pq_q && !phase_q) begin
                  // First (high) byte of a 16-bit entry
                  dqt_hi_d = s_data;
                  phase_d  = 1'b1;
               end else begin
                  dqt_we_d   = 1'b1;
                  dqt_id_d   = tq_q;
                  dqt_addr_d = cnt_q[5:0];
                  dqt_data_d = pq_q ? {dqt_hi_q, s_data} : {8'd0, s_data};
                  phase_d    = 1'b0;
                  cnt_d      = cnt_q + 8'd1;
                  if (cnt_q == 8'd63) state_d = rem_last ? ST_MRK_FF : ST_DQT_PQ;
               end
            end
         end
         ST_DHT_TC: begin
            if (body_byte) begin
               if ((s_data[7:4] > 4'd1) || (s_data[3:0] > 4'd1)) begin
                  err_set   = 1'b1;
                  err_cause = ERR_BAD_TABLE;
               end else begin
                  dht_sel_d = {s_data[4], s_data[0]};
                  cnt_d     = 8'd0;
                  sum_d     = 12'd0;
                  state_d   = ST_DHT_BITS;
               end
            end
         end
         ST_DHT_BITS: begin
            if (body_byte) begin
               dht_bits_we_d  = 1'b1;
               dht_bits_idx_d = cnt_q[3:0];
               dht_data_d     = s_data;
               sum_d          = sum_next;
               cnt_d          = cnt_q + 8'd1;
               if (cnt_q == 8'd15) begin
                  cnt_d = 8'd0;
                  if (sum_next > 12'd255) begin
                     err_set   = 1'b1;
                     err_cause = ERR_DHT_COUNT;
                  end else if (sum_next == 12'd0) begin
                     state_d = rem_last ? ST_MRK_FF : ST_DHT_TC;
                  end else begin
                     state_d = ST_DHT_VALS;
                  end
               end
            end
         end
         ST_DHT_VALS: begin
            if (body_byte) begin
               dht_vals_we_d  = 1'b1;
               dht_vals_idx_d = cnt_q;
               dht_data_d     = s_data;
               cnt_d          = cnt_q + 8'd1;
               if ({4'd0, cnt_q} == (sum_q - 12'd1)) begin
                  state_d = rem_last ? ST_MRK_FF : ST_DHT_TC;
               end
            end
         end
         ST_SOF_BODY: begin
            if (body_byte) begin
               cnt_d = cnt_q + 8'd1;
               case (cnt_q)
                  8'd1: height_d[15:8] = s_data;
                  8'd2: height_d[7:0]  = s_data;
                  8'd3: width_d[15:8]  = s_data;
                  8'd4: width_d[7:0]   = s_data;
                  8'd5: begin
                     if ((s_data == 8'd0) || (s_data > MAX_COMP_B)) begin
                        err_set   = 1'b1;
                        err_cause = ERR_BAD_NCOMP;
                     end else begin
                        num_comp_d = s_data[2:0];
                     end
                  end
                  8'd7: begin
                     samp_h_d = s_data[5:4];
                     samp_v_d = s_data[1:0];
                  end
                  default: ;
               endcase
               // Trailing bytes beyond the component list are skipped
               if ((cnt_q > 8'd5) && (cnt_q == sof_last)) begin
                  state_d = rem_last ? ST_MRK_FF : ST_SKIP;
               end
            end
         end
         ST_SOS_BODY: begin
            if (body_byte) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd0) begin
                  if ((s_data == 8'd0) || (s_data > {5'd0, num_comp_q})) begin
                     err_set   = 1'b1;
                     err_cause = ERR_BAD_NCOMP;
                  end else begin
                     scan_ncomp_d = s_data[2:0];
                  end
               end else if (cnt_q == sos_last) begin
                  state_d      = ST_SCAN;
                  scan_start_d = 1'b1;
               end
            end
         end
         ST_DRI_BODY: begin
            if (body_byte) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd0) begin
                  restart_d[15:8] = s_data;
               end else begin
                  restart_d[7:0] = s_data;
                  state_d        = ST_MRK_FF;
               end
            end
         end
         ST_SCAN: begin
            if (scan_done) state_d = ST_MRK_FF;
         end
         default: ;
      endcase

      // Any error parks the FSM and suppresses this cycle's strobes
      if (err_set) begin
         state_d       = ST_ERROR;
         dqt_we_d      = 1'b0;
         dht_bits_we_d = 1'b0;
         dht_vals_we_d = 1'b0;
         scan_start_d  = 1'b0;
         eoi_d         = 1'b0;
         err_d         = 1'b1;
         if (!err_q) err_code_d = err_cause;
      end
   end

   // State and output registers; reset aborts any segment in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         seg_q          <= SEG_SKIP;
         len_hi_q       <= 8'd0;
         cnt_q          <= 8'd0;
         tq_q           <= 2'd0;
         pq_q           <= 1'b0;
         phase_q        <= 1'b0;
         dqt_hi_q       <= 8'd0;
         sum_q          <= 12'd0;
         dqt_we_q       <= 1'b0;
         dqt_id_q       <= 2'd0;
         dqt_addr_q     <= 6'd0;
         dqt_data_q     <= 16'd0;
         dht_bits_we_q  <= 1'b0;
         dht_vals_we_q  <= 1'b0;
         dht_sel_q      <= 2'd0;
         dht_bits_idx_q <= 4'd0;
         dht_vals_idx_q <= 8'd0;
         dht_data_q     <= 8'd0;
         width_q        <= 16'd0;
         height_q       <= 16'd0;
         num_comp_q     <= 3'd0;
         progressive_q  <= 1'b0;
         samp_h_q       <= 2'd0;
         samp_v_q       <= 2'd0;
         restart_q      <= 16'd0;
         scan_ncomp_q   <= 3'd0;
         scan_start_q   <= 1'b0;
         eoi_q          <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= ERR_NONE;
      end else begin
         state_q        <= state_d;
         seg_q          <= seg_d;
         len_hi_q       <= len_hi_d;
         cnt_q          <= cnt_d;
         tq_q           <= tq_d;
         pq_q           <= pq_d;
         phase_q        <= phase_d;
         dqt_hi_q       <= dqt_hi_d;
         sum_q          <= sum_d;
         dqt_we_q       <= dqt_we_d;
         dqt_id_q       <= dqt_id_d;
         dqt_addr_q     <= dqt_addr_d;
         dqt_data_q     <= dqt_data_d;
         dht_bits_we_q  <= dht_bits_we_d;
         dht_vals_we_q  <= dht_vals_we_d;
         dht_sel_q      <= dht_sel_d;
         dht_bits_idx_q <= dht_bits_idx_d;
         dht_vals_idx_q <= dht_vals_idx_d;
         dht_data_q     <= dht_data_d;
         width_q        <= width_d;
         height_q       <= height_d;
         num_comp_q     <= num_comp_d;
         progressive_q  <= progressive_d;
         samp_h_q       <= samp_h_d;
         samp_v_q       <= samp_v_d;
         restart_q      <= restart_d;
         scan_ncomp_q   <= scan_ncomp_d;
         scan_start_q   <= scan_start_d;
         eoi_q          <= eoi_d;
         err_q          <= err_d;
         err_code_q     <= err_code_d;
      end
   end

   assign idle             = (state_q == ST_IDLE);
   assign state_dbg        = state_q;
   assign dqt_we           = dqt_we_q;
   assign dqt_id           = dqt_id_q;
   assign dqt_addr         = dqt_addr_q;
   assign dqt_data         = dqt_data_q;
   assign dht_bits_we      = dht_bits_we_q;
   assign dht_vals_we      = dht_vals_we_q;
   assign dht_sel          = dht_sel_q;
   assign dht_bits_idx     = dht_bits_idx_q;
   assign dht_vals_idx     = dht_vals_idx_q;
   assign dht_data         = dht_data_q;
   assign width            = width_q;
   assign height           = height_q;
   assign num_comp         = num_comp_q;
   assign progressive      = progressive_q;
   assign samp_h           = samp_h_q;
   assign samp_v           = samp_v_q;
   assign restart_interval = restart_q;
   assign scan_ncomp       = scan_ncomp_q;
   assign scan_start       = scan_start_q;
   assign eoi              = eoi_q;
   assign err              = err_q;
   assign err_code         = err_code_q;

endmodule

// File: tb/tb_aq_djpeg_marker_parser.sv
// Bench for the JPEG marker parser: a marker/length table plus hand-built
// header streams; every table write and pulse is matched against a queue.
module tb_aq_djpeg_marker_parser;

   logic        clk = 1'b0;
   logic        rst, start, s_valid, scan_done;
   logic [7:0]  s_data;
   logic        s_ready, idle;
   logic        dqt_we, dht_bits_we, dht_vals_we;
   logic [1:0]  dqt_id, dht_sel, samp_h, samp_v;
   logic [5:0]  dqt_addr;
   logic [15:0] dqt_data, width, height, restart_interval;
   logic [3:0]  dht_bits_idx, state_dbg;
   logic [7:0]  dht_vals_idx, dht_data;
   logic [2:0]  num_comp, scan_ncomp, err_code;
   logic        progressive, scan_start, eoi, err;

   int vectors = 0;
   int miscompares = 0;

   // Scoreboard word: {kind[1:0], sel/id[1:0], idx[7:0], data[15:0]}
   // kind 0 = dqt write, 1 = dht count, 2 = dht symbol, 3 = pulse
   logic [27:0] exp_q[$];

   typedef struct {
      logic [7:0]  mrk;
      logic [15:0] len;
      logic [2:0]  code;
   } mrk_vec_t;
   mrk_vec_t tbl[14];

   aq_djpeg_marker_parser dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .s_valid          (s_valid),
      .s_data           (s_data),
      .s_ready          (s_ready),
      .scan_done        (scan_done),
      .idle             (idle),
      .dqt_we           (dqt_we),
      .dqt_id           (dqt_id),
      .dqt_addr         (dqt_addr),
      .dqt_data         (dqt_data),
      .dht_bits_we      (dht_bits_we),
      .dht_sel          (dht_sel),
      .dht_bits_idx     (dht_bits_idx),
      .dht_vals_we      (dht_vals_we),
      .dht_vals_idx     (dht_vals_idx),
      .dht_data         (dht_data),
      .width            (width),
      .height           (height),
      .num_comp         (num_comp),
      .progressive      (progressive),
      .samp_h           (samp_h),
      .samp_v           (samp_v),
      .restart_interval (restart_interval),
      .scan_ncomp       (scan_ncomp),
      .scan_start       (scan_start),
      .eoi              (eoi),
      .err              (err),
      .err_code         (err_code),
      .state_dbg        (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic sb_obs(input string name, input logic [27:0] act);
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s: got %07h expected nothing", name, act);
      end else begin
         logic [27:0] e;
         e = exp_q.pop_front();
         if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got %07h expected %07h", name, act, e);
         end
      end
   endtask

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (dqt_we)      sb_obs("dqt_write", {2'd0, dqt_id, 2'b00, dqt_addr, dqt_data});
      if (dht_bits_we) sb_obs("dht_bits", {2'd1, dht_sel, 4'h0, dht_bits_idx, 8'h00, dht_data});
      if (dht_vals_we) sb_obs("dht_vals", {2'd2, dht_sel, dht_vals_idx, 8'h00, dht_data});
      if (eoi)         sb_obs("eoi_pulse", {2'd3, 2'b00, 8'h00, 16'h0001});
      if (scan_start)  sb_obs("scan_start_pulse", {2'd3, 2'b00, 8'h00, 16'h0002});
   end

   // Driver tasks
   task automatic push_dqt(input logic [1:0] id, input logic [5:0] a, input logic [15:0] d);
      exp_q.push_back({2'd0, id, 2'b00, a, d});
   endtask
   task automatic push_bits(input logic [1:0] sel, input logic [3:0] i, input logic [7:0] d);
      exp_q.push_back({2'd1, sel, 4'h0, i, 8'h00, d});
   endtask
   task automatic push_vals(input logic [1:0] sel, input logic [7:0] i, input logic [7:0] d);
      exp_q.push_back({2'd2, sel, i, 8'h00, d});
   endtask
   task automatic push_evt(input logic [15:0] code);
      exp_q.push_back({2'd3, 2'b00, 8'h00, code});
   endtask

   task automatic do_reset();
      rst = 1'b1; s_valid = 1'b0; start = 1'b0; scan_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && waited < 200) begin
         @(posedge clk);
         #1 waited++;
      end
      if (!s_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: got s_ready=0 expected byte %02h accepted", b);
      end else begin
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic send_eoi();
      send_byte(8'hFF);
      push_evt(16'h0001);
      send_byte(8'hD9);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; scan_done = 1'b0;

      // {marker, length, expected err_code}; 0 means the segment is skipped cleanly
      tbl[0]  = '{8'hE0, 16'd4, 3'd0};
      tbl[1]  = '{8'hFE, 16'd2, 3'd0};
      tbl[2]  = '{8'hC8, 16'd3, 3'd0};
      tbl[3]  = '{8'hCC, 16'd2, 3'd0};
      tbl[4]  = '{8'hDB, 16'd2, 3'd0};
      tbl[5]  = '{8'hC4, 16'd2, 3'd0};
      tbl[6]  = '{8'hC3, 16'd0, 3'd2};
      tbl[7]  = '{8'hC5, 16'd0, 3'd2};
      tbl[8]  = '{8'hC7, 16'd0, 3'd2};
      tbl[9]  = '{8'hCF, 16'd0, 3'd2};
      tbl[10] = '{8'hE0, 16'd1, 3'd3};
      tbl[11] = '{8'hDB, 16'd0, 3'd3};
      tbl[12] = '{8'hDD, 16'd5, 3'd3};
      tbl[13] = '{8'hDD, 16'd3, 3'd3};

      // Reset state
      do_reset();
      chk("rst_idle", idle, 1);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_width", width, 0);
      chk("rst_height", height, 0);
      chk("rst_restart", restart_interval, 0);
      chk("rst_num_comp", num_comp, 0);
      do_start();
      chk("start_s_ready", s_ready, 1);

      // Marker classification and length checks
      for (int i = 0; i < 14; i++) begin
         do_reset();
         do_start();
         send_byte(8'hFF); send_byte(8'hD8);
         send_byte(8'hFF); send_byte(tbl[i].mrk);
         if (tbl[i].code != 3'd2) begin
            send_byte(tbl[i].len[15:8]);
            send_byte(tbl[i].len[7:0]);
            if (tbl[i].code == 3'd0) begin
               for (int k = 2; k < int'(tbl[i].len); k++) send_byte(8'h5A);
               send_eoi();
            end
         end
         chk($sformatf("tbl%0d_err", i), err, (tbl[i].code != 3'd0) ? 1 : 0);
         chk($sformatf("tbl%0d_err_code", i), err_code, tbl[i].code);
         chk($sformatf("tbl%0d_idle", i), idle, (tbl[i].code == 3'd0) ? 1 : 0);
      end

      // 8-bit DQT, table 1, values 1..64, then EOI
      do_reset();
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hDB); send_byte(8'h00); send_byte(8'h43);
      send_byte(8'h01);
      for (int k = 0; k < 64; k++) begin
         push_dqt(2'd1, 6'(k), 16'(k + 1));
         send_byte(8'(k + 1));
      end
      send_eoi();
      chk("dqt_idle", idle, 1);
      chk("dqt_err", err, 0);

      // Full header: SOF0, DHT, DRI, SOS, scan, EOI
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hC0); send_byte(8'h00); send_byte(8'h11);
      send_byte(8'h08); send_byte(8'h00); send_byte(8'hF0); send_byte(8'h01); send_byte(8'h40);
      send_byte(8'h03);
      send_byte(8'h01); send_byte(8'h22); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h11); send_byte(8'h01);
      send_byte(8'h03); send_byte(8'h11); send_byte(8'h01);
      chk("sof_width", width, 320);
      chk("sof_height", height, 240);
      chk("sof_num_comp", num_comp, 3);
      chk("sof_samp_h", samp_h, 2);
      chk("sof_samp_v", samp_v, 2);
      chk("sof_progressive", progressive, 0);

      send_byte(8'hFF); send_byte(8'hC4); send_byte(8'h00); send_byte(8'h16);
      send_byte(8'h10);
      for (int k = 0; k < 16; k++) begin
         logic [7:0] c;
         c = (k == 1) ? 8'd2 : (k == 2) ? 8'd1 : 8'd0;
         push_bits(2'd2, 4'(k), c);
         send_byte(c);
      end
      for (int k = 0; k < 3; k++) begin
         push_vals(2'd2, 8'(k), 8'(8'h05 + k));
         send_byte(8'(8'h05 + k));
      end

      send_byte(8'hFF); send_byte(8'hDD); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'h00); send_byte(8'h10);
      chk("dri_restart", restart_interval, 16);

      send_byte(8'hFF); send_byte(8'hDA); send_byte(8'h00); send_byte(8'h0C);
      send_byte(8'h03);
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h11);
      send_byte(8'h03); send_byte(8'h11); send_byte(8'h00); send_byte(8'h3F);
      push_evt(16'h0002);
      send_byte(8'h00);
      chk("sos_scan_ncomp", scan_ncomp, 3);
      repeat (5) @(posedge clk);
      #1;
      chk("scan_s_ready", s_ready, 0);
      chk("scan_state", state_dbg, 14);
      scan_done = 1'b1;
      @(posedge clk);
      #1 scan_done = 1'b0;
      chk("scan_done_s_ready", s_ready, 1);
      send_eoi();
      chk("hdr_idle", idle, 1);
      chk("hdr_err", err, 0);

      // SOF2 with too many components
      do_reset();
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hC2); send_byte(8'h00); send_byte(8'h17);
      send_byte(8'h08); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h05);
      chk("nf5_err", err, 1);
      chk("nf5_err_code", err_code, 6);
      chk("nf5_s_ready", s_ready, 0);
      chk("nf5_progressive", progressive, 1);
      do_start();
      chk("nf5_start_ignored", idle, 0);
      chk("nf5_code_held", err_code, 6);
      do_reset();
      chk("nf5_rst_idle", idle, 1);
      chk("nf5_rst_err", err, 0);
      chk("nf5_rst_code", err_code, 0);

      // Reset mid-DQT, then two tables (8-bit Tq=0 and 16-bit Tq=3)
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hDB); send_byte(8'h00); send_byte(8'h43);
      send_byte(8'h02);
      for (int k = 0; k < 10; k++) begin
         push_dqt(2'd2, 6'(k), 16'(k + 8'h30));
         send_byte(8'(k + 8'h30));
      end
      s_valid = 1'b1; s_data = 8'h77;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      s_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_idle", idle, 1);
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hDB); send_byte(8'h00); send_byte(8'hC4);
      send_byte(8'h00);
      for (int k = 0; k < 64; k++) begin
         push_dqt(2'd0, 6'(k), 16'(8'd200 - k));
         send_byte(8'(8'd200 - k));
      end
      send_byte(8'h13);
      for (int k = 0; k < 64; k++) begin
         logic [7:0] hi, lo;
         hi = 8'(k);
         lo = 8'hA0 ^ 8'(k);
         push_dqt(2'd3, 6'(k), {hi, lo});
         send_byte(hi);
         send_byte(lo);
      end
      send_eoi();
      chk("dqt2_idle", idle, 1);
      chk("dqt2_err", err, 0);

      // Table running past the segment length
      do_reset();
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hDB); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h00);
      for (int k = 0; k < 13; k++) begin
         push_dqt(2'd0, 6'(k), 16'(k + 9));
         send_byte(8'(k + 9));
      end
      send_byte(8'hEE);
      chk("ovr_err", err, 1);
      chk("ovr_err_code", err_code, 7);
      chk("ovr_state", state_dbg, 15);

      // DHT code counts summing past 255
      do_reset();
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hC4); send_byte(8'h00); send_byte(8'h13);
      send_byte(8'h01);
      for (int k = 0; k < 16; k++) begin
         if (k < 15) push_bits(2'd1, 4'(k), 8'h10);
         send_byte(8'h10);
      end
      chk("dhtsum_err_code", err_code, 5);

      // Invalid DQT table id
      do_reset();
      do_start();
      send_byte(8'hFF); send_byte(8'hD8);
      send_byte(8'hFF); send_byte(8'hDB); send_byte(8'h00); send_byte(8'h43);
      send_byte(8'h04);
      chk("dqt_tq_err_code", err_code, 4);

      // First byte not 0xFF
      do_reset();
      do_start();
      send_byte(8'h12);
      chk("badmrk_err_code", err_code, 1);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
